// File: rtl/core_program_loader_pkg.sv
// core_program_loader_pkg: command, state and header types shared by the boot loader files.
package core_program_loader_pkg;

   localparam int LOADER_LEN_W = 10;
   localparam int LOADER_HDR_ADDR_W = 10;

   typedef enum logic [1:0] {
      CMD_PROG  = 2'b00,
      CMD_DATA  = 2'b01,
      CMD_START = 2'b10,
      CMD_ABORT = 2'b11
   } loader_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } loader_state_e;

   typedef struct packed {
      loader_cmd_e                  cmd;
      logic [8:0]                   rsvd_hi;
      logic [LOADER_LEN_W-1:0]      len_m1;
      logic                         rsvd_lo;
      logic [LOADER_HDR_ADDR_W-1:0] addr;
   } loader_hdr_t;

   function automatic loader_hdr_t loader_hdr_decode(input logic [31:0] word);
      return loader_hdr_t'(word);
   endfunction

endpackage

// File: rtl/loader_mem_writer.sv
// loader_mem_writer: one-cycle-latency write strobe/address/data generator for the core load ports,
// with a base-loadable address counter that wraps at 2^ADDR_W.
module loader_mem_writer #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              wr_en,
   input  logic              sel_data,
   input  logic [DATA_W-1:0] wr_data,
   output logic              prog_ctrl,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [DATA_W-1:0] prog_data,
   output logic              data_ctrl,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_data
);

   logic [ADDR_W-1:0] addr_cnt;
   logic              vld_p1;
   logic              sel_p1;
   logic [ADDR_W-1:0] prog_addr_p1;
   logic [DATA_W-1:0] prog_data_p1;
   logic [ADDR_W-1:0] data_addr_p1;
   logic [DATA_W-1:0] data_data_p1;

   // p0 -> p1: accepted payload word becomes a registered write on the selected port
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_cnt     <= '0;
         vld_p1       <= 1'b0;
         sel_p1       <= 1'b0;
         prog_addr_p1 <= '0;
         prog_data_p1 <= '0;
         data_addr_p1 <= '0;
         data_data_p1 <= '0;
      end else begin
         vld_p1 <= wr_en;
         if (load_en) begin
            addr_cnt <= base_addr;
         end else if (wr_en) begin
            addr_cnt <= addr_cnt + 1'b1;
         end
         if (wr_en) begin
            sel_p1 <= sel_data;
            if (sel_data) begin
               data_addr_p1 <= addr_cnt;
               data_data_p1 <= wr_data;
            end else begin
               prog_addr_p1 <= addr_cnt;
               prog_data_p1 <= wr_data;
            end
         end
      end
   end

   assign prog_ctrl = vld_p1 && !sel_p1;
   assign data_ctrl = vld_p1 && sel_p1;
   assign prog_addr = prog_addr_p1;
   assign prog_data = prog_data_p1;
   assign data_addr = data_addr_p1;
   assign data_data = data_data_p1;

endmodule

// File: rtl/core_program_loader.sv
// core_program_loader: stream boot loader that fills instruction/data memory, runs the core and times it.
// Build macro LOADER_CHECKSUM_EN appends an XOR checksum word to every load block.
module core_program_loader
   import core_program_loader_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int RST_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [31:0]       IN_DATA,
   output logic              PROG_CTRL,
   output logic [ADDR_W-1:0] PROG_ADDR,
   output logic [DATA_W-1:0] PROG_DATA,
   output logic              DATA_CTRL,
   output logic [ADDR_W-1:0] DATA_ADDR,
   output logic [DATA_W-1:0] DATA_DATA,
   output logic              CORE_RSTn,
   output logic              CORE_START,
   input  logic              CORE_OK,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [31:0]       RUN_CYCLES
);

   localparam int AC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   loader_state_e           state;
   loader_hdr_t             hdr;
   logic [LOADER_LEN_W-1:0] len_cnt;
   logic [AC_W-1:0]         abort_cnt;
   logic                    tgt_data;
   logic                    err;
   logic                    done;
   logic                    core_rstn;
   logic                    core_start;
   logic [31:0]             run_cycles;
   logic                    accept_p0;
   logic                    wr_en_p0;
   logic                    load_en_p0;
   logic                    start_ok;
   logic                    unused_hdr_bits;

`ifdef LOADER_CHECKSUM_EN
   logic                    csum_wait;
   logic [31:0]             csum_acc;
   assign start_ok = !err;
   assign wr_en_p0 = accept_p0 && (state == ST_LOAD) && !csum_wait;
`else
   assign start_ok = 1'b1;
   assign wr_en_p0 = accept_p0 && (state == ST_LOAD);
`endif

   assign hdr             = loader_hdr_decode(IN_DATA);
   assign unused_hdr_bits = ^{hdr.rsvd_hi, hdr.rsvd_lo};
   assign IN_READY        = !RST && (state != ST_ABORT);
   assign accept_p0       = IN_VALID && IN_READY;
   assign load_en_p0      = accept_p0 && ((state == ST_IDLE) || (state == ST_DONE)) &&
                            ((hdr.cmd == CMD_PROG) || (hdr.cmd == CMD_DATA));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         len_cnt    <= '0;
         abort_cnt  <= '0;
         tgt_data   <= 1'b0;
         err        <= 1'b0;
         done       <= 1'b0;
         core_rstn  <= 1'b0;
         core_start <= 1'b0;
         run_cycles <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_wait  <= 1'b0;
         csum_acc   <= '0;
`endif
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (accept_p0) begin
                  unique case (hdr.cmd)
                     CMD_PROG, CMD_DATA: begin
                        state      <= ST_LOAD;
                        tgt_data   <= (hdr.cmd == CMD_DATA);
                        len_cnt    <= hdr.len_m1;
                        done       <= 1'b0;
                        core_rstn  <= 1'b0;
                        core_start <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_wait  <= 1'b0;
                        csum_acc   <= '0;
`endif
                     end
                     CMD_START: begin
                        done       <= 1'b0;
                        core_start <= 1'b0;
                        if (start_ok) begin
                           // Restart from DONE gives the core one reset cycle before it is released
                           state      <= ST_RUN;
                           core_rstn  <= (state == ST_IDLE);
                           run_cycles <= '0;
                        end else begin
                           state     <= ST_IDLE;
                           core_rstn <= 1'b0;
                        end
                     end
                     CMD_ABORT: begin
                        if (state == ST_DONE) begin
                           state      <= ST_ABORT;
                           abort_cnt  <= AC_W'(RST_CYCLES - 1);
                           core_rstn  <= 1'b0;
                           core_start <= 1'b0;
                           err        <= 1'b0;
                           done       <= 1'b0;
                           run_cycles <= '0;
                        end
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               if (accept_p0) begin
`ifdef LOADER_CHECKSUM_EN
                  if (csum_wait) begin
                     csum_wait <= 1'b0;
                     state     <= ST_IDLE;
                     if (IN_DATA != csum_acc) begin
                        err <= 1'b1;
                     end
                  end else begin
                     csum_acc <= csum_acc ^ IN_DATA;
                     len_cnt  <= len_cnt - 1'b1;
                     if (len_cnt == '0) begin
                        csum_wait <= 1'b1;
                     end
                  end
`else
                  len_cnt <= len_cnt - 1'b1;
                  if (len_cnt == '0) begin
                     state <= ST_IDLE;
                  end
`endif
               end
            end
            ST_RUN: begin
               core_rstn  <= 1'b1;
               core_start <= core_rstn;
               if (accept_p0 && (hdr.cmd == CMD_ABORT)) begin
                  state      <= ST_ABORT;
                  abort_cnt  <= AC_W'(RST_CYCLES - 1);
                  core_rstn  <= 1'b0;
                  core_start <= 1'b0;
                  err        <= 1'b0;
                  done       <= 1'b0;
                  run_cycles <= '0;
               end else begin
                  if (accept_p0) begin
                     err <= 1'b1;
                  end
                  if (CORE_OK) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     run_cycles <= sat_inc(run_cycles);
                  end
               end
            end
            ST_ABORT: begin
               if (abort_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  abort_cnt <= abort_cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   loader_mem_writer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_writer (
      .clk       (CLK),
      .rst       (RST),
      .load_en   (load_en_p0),
      .base_addr (ADDR_W'(hdr.addr)),
      .wr_en     (wr_en_p0),
      .sel_data  (tgt_data),
      .wr_data   (DATA_W'(IN_DATA)),
      .prog_ctrl (PROG_CTRL),
      .prog_addr (PROG_ADDR),
      .prog_data (PROG_DATA),
      .data_ctrl (DATA_CTRL),
      .data_addr (DATA_ADDR),
      .data_data (DATA_DATA)
   );

   assign BUSY       = (state != ST_IDLE) && (state != ST_DONE);
   assign DONE       = done;
   assign ERR        = err;
   assign CORE_RSTn  = core_rstn;
   assign CORE_START = core_start;
   assign RUN_CYCLES = run_cycles;

endmodule

// File: tb/tb_core_program_loader.sv
// tb_core_program_loader: directed and randomized bench for the boot loader against a memory/timing model.
module tb_core_program_loader;

   logic        CLK;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] IN_DATA;
   logic        PROG_CTRL;
   logic [9:0]  PROG_ADDR;
   logic [31:0] PROG_DATA;
   logic        DATA_CTRL;
   logic [9:0]  DATA_ADDR;
   logic [31:0] DATA_DATA;
   logic        CORE_RSTn;
   logic        CORE_START;
   logic        CORE_OK;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [31:0] RUN_CYCLES;

   core_program_loader dut (
      .CLK        (CLK),
      .RST        (RST),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN_DATA    (IN_DATA),
      .PROG_CTRL  (PROG_CTRL),
      .PROG_ADDR  (PROG_ADDR),
      .PROG_DATA  (PROG_DATA),
      .DATA_CTRL  (DATA_CTRL),
      .DATA_ADDR  (DATA_ADDR),
      .DATA_DATA  (DATA_DATA),
      .CORE_RSTn  (CORE_RSTn),
      .CORE_START (CORE_START),
      .CORE_OK    (CORE_OK),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR),
      .RUN_CYCLES (RUN_CYCLES)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference memories: what the core's memories must hold after all loads
   logic [31:0] exp_p [1024];
   logic [31:0] exp_d [1024];
   bit          t_p   [1024];
   bit          t_d   [1024];
   int          exp_strobes = 0;

   logic [31:0] obs_p [1024];
   logic [31:0] obs_d [1024];
   int          obs_strobes = 0;

   always @(negedge CLK) begin
      if (PROG_CTRL) begin
         obs_p[PROG_ADDR] = PROG_DATA;
         obs_strobes++;
      end
      if (DATA_CTRL) begin
         obs_d[DATA_ADDR] = DATA_DATA;
         obs_strobes++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      IN_VALID = 1'b0;
      IN_DATA  = $urandom;
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      IN_VALID = 1'b1;
      IN_DATA  = w;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic model_write(input bit is_data, input int a, input logic [31:0] w);
      if (is_data) begin
         exp_d[a] = w;
         t_d[a]   = 1'b1;
      end else begin
         exp_p[a] = w;
         t_p[a]   = 1'b1;
      end
      exp_strobes++;
   endtask

   function automatic logic [31:0] mk_hdr(input logic [1:0] cmd, input int len, input int base);
      return {cmd, 9'd0, 10'(len - 1), 1'b0, 10'(base)};
   endfunction

   task automatic load_block(input logic [1:0] cmd, input int base, input logic [31:0] words [$],
                             input bit gaps);
      int a;
      bit is_data;
`ifdef LOADER_CHECKSUM_EN
      logic [31:0] sum;
      sum = '0;
`endif
      is_data = (cmd == 2'b01);
      send(mk_hdr(cmd, words.size(), base));
      chk("hdr_busy", 32'(BUSY), 1);
      chk("hdr_done_clr", 32'(DONE), 0);
      chk("hdr_start_low", 32'(CORE_START), 0);
      for (int i = 0; i < words.size(); i++) begin
         if (gaps && i > 0) begin
            idle_cycle();
            chk("gap_no_strobe", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
         end
         send(words[i]);
         a = (base + i) % 1024;
         model_write(is_data, a, words[i]);
`ifdef LOADER_CHECKSUM_EN
         sum = sum ^ words[i];
`endif
         chk("strobe_sel", {30'd0, PROG_CTRL, DATA_CTRL}, is_data ? 32'd1 : 32'd2);
         chk("strobe_addr", 32'(is_data ? DATA_ADDR : PROG_ADDR), 32'(a));
         chk("strobe_data", is_data ? DATA_DATA : PROG_DATA, words[i]);
         chk("load_rstn", 32'(CORE_RSTn), 0);
      end
`ifdef LOADER_CHECKSUM_EN
      send(sum);
      chk("csum_no_strobe", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      chk("csum_err", 32'(ERR), 0);
`endif
      chk("load_end_busy", 32'(BUSY), 0);
      idle_cycle();
      chk("post_load_quiet", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
   endtask

   task automatic rand_block(input bit gaps);
      logic [31:0] q [$];
      int n;
      n = $urandom_range(1, 8);
      q = {};
      repeat (n) q.push_back($urandom);
      load_block(2'($urandom_range(0, 1)), $urandom_range(0, 1023), q, gaps);
   endtask

   // k = cycles the core runs with CORE_OK low after being started
   task automatic run_core(input int k);
      send(32'h8000_0000);
      chk("run_rstn", 32'(CORE_RSTn), 1);
      chk("run_start_lag", 32'(CORE_START), 0);
      chk("run_busy", 32'(BUSY), 1);
      chk("run_cyc_clr", RUN_CYCLES, 0);
      for (int i = 1; i <= k; i++) begin
         idle_cycle();
         if (i == 1) chk("run_start", 32'(CORE_START), 1);
      end
      CORE_OK = 1'b1;
      idle_cycle();
      CORE_OK = 1'b0;
      chk("done_flag", 32'(DONE), 1);
      chk("done_busy", 32'(BUSY), 0);
      chk("done_cycles", RUN_CYCLES, 32'(k));
      chk("done_start_hold", 32'(CORE_START), 1);
      repeat (3) idle_cycle();
      chk("cycles_frozen", RUN_CYCLES, 32'(k));
      chk("done_hold", 32'(DONE), 1);
   endtask

   task automatic expect_abort();
      chk("abort_start", 32'(CORE_START), 0);
      chk("abort_rstn", 32'(CORE_RSTn), 0);
      chk("abort_ready", 32'(IN_READY), 0);
      chk("abort_err_clr", 32'(ERR), 0);
      chk("abort_done_clr", 32'(DONE), 0);
      chk("abort_cyc_clr", RUN_CYCLES, 0);
      for (int i = 0; i < 3; i++) begin
         idle_cycle();
         chk("abort_hold_ready", 32'(IN_READY), 0);
         chk("abort_hold_rstn", 32'(CORE_RSTn), 0);
      end
      idle_cycle();
      chk("abort_exit_ready", 32'(IN_READY), 1);
      chk("abort_exit_busy", 32'(BUSY), 0);
      chk("abort_exit_rstn", 32'(CORE_RSTn), 0);
   endtask

   initial begin
      logic [31:0] q [$];
      logic [31:0] w0;
      logic [31:0] w1;
      int          base;

      RST      = 1'b1;
      IN_VALID = 1'b0;
      IN_DATA  = '0;
      CORE_OK  = 1'b0;

      @(posedge CLK);
      #1;
      chk("rst_ready", 32'(IN_READY), 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      chk("rst_ctrl", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      chk("rst_paddr", 32'(PROG_ADDR), 0);
      chk("rst_pdata", PROG_DATA, 0);
      chk("rst_daddr", 32'(DATA_ADDR), 0);
      chk("rst_ddata", DATA_DATA, 0);
      chk("rst_core", {30'd0, CORE_RSTn, CORE_START}, 0);
      chk("rst_flags", {29'd0, BUSY, DONE, ERR}, 0);
      chk("rst_cycles", RUN_CYCLES, 0);
      chk("idle_ready", 32'(IN_READY), 1);

      send(32'hC000_0000);
      chk("idle_abort_noop", {30'd0, IN_READY, BUSY}, 32'd2);

      q = {32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
      load_block(2'b00, 0, q, 1'b0);
      q = {32'd1, 32'd2, 32'd3};
      load_block(2'b01, 1023, q, 1'b0);
      q = {32'hC000_0000, 32'h8000_0000, $urandom, $urandom};
      load_block(2'b01, $urandom_range(0, 1023), q, 1'b1);
      repeat (4) rand_block(1'($urandom_range(0, 1)));

      run_core(20);
      send(32'hC000_0000);
      expect_abort();

      send(32'h8000_0000);
      idle_cycle();
      send(32'h0000_0000);
      chk("run_bad_hdr_err", 32'(ERR), 1);
      chk("run_bad_hdr_busy", 32'(BUSY), 1);
      chk("run_bad_hdr_strobe", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      idle_cycle();
      chk("run_bad_hdr_quiet", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      send(32'hC000_0000);
      expect_abort();

      send(32'h8000_0000);
      repeat (2) idle_cycle();
      CORE_OK = 1'b1;
      send(32'hC000_0000);
      CORE_OK = 1'b0;
      expect_abort();

      run_core($urandom_range(3, 30));
      rand_block(1'b0);

      base = $urandom_range(0, 1023);
      w0 = $urandom;
      w1 = $urandom;
      send(mk_hdr(2'b00, 4, base));
      send(w0);
      model_write(1'b0, base, w0);
      send(w1);
      model_write(1'b0, (base + 1) % 1024, w1);
      RST      = 1'b1;
      IN_VALID = 1'b1;
      IN_DATA  = $urandom;
      @(posedge CLK);
      #1;
      RST      = 1'b0;
      IN_VALID = 1'b0;
      chk("midrst_strobe", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      chk("midrst_busy", 32'(BUSY), 0);
      idle_cycle();
      chk("midrst_quiet", {30'd0, PROG_CTRL, DATA_CTRL}, 0);

`ifdef LOADER_CHECKSUM_EN
      base = $urandom_range(0, 1023);
      send(mk_hdr(2'b01, 2, base));
      send(32'h0000_00F0);
      model_write(1'b1, base, 32'h0000_00F0);
      send(32'h0000_000F);
      model_write(1'b1, (base + 1) % 1024, 32'h0000_000F);
      send(32'h0000_0000);
      chk("csum_bad_err", 32'(ERR), 1);
      chk("csum_bad_strobe", {30'd0, PROG_CTRL, DATA_CTRL}, 0);
      send(32'h8000_0000);
      idle_cycle();
      chk("csum_refuse_start", 32'(CORE_START), 0);
      chk("csum_refuse_busy", 32'(BUSY), 0);
`else
      run_core($urandom_range(1, 6));
`endif

      chk("strobe_count", 32'(obs_strobes), 32'(exp_strobes));
      for (int a = 0; a < 1024; a++) begin
         if (t_p[a]) chk("imem_word", obs_p[a], exp_p[a]);
         if (t_d[a]) chk("dmem_word", obs_d[a], exp_d[a]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_program_loader.md
Name: core_program_loader

Overview:
- Stream-driven boot loader directly upstream of the pipelined RISC-V datapath.
- Accepts a 32-bit word stream (valid/ready) of command headers and payloads.
- Writes payload into the instruction and data memories through the datapath's load ports, holds the core in reset while loading, then releases reset and raises START.
- Watches the core's OK flag and reports completion plus an execution cycle count.

Parameters:
- ADDR_W, 10, memory word-address width (matches the load-port address width).
- DATA_W, 32, load data width.
- RST_CYCLES, 4, cycles CORE_RSTn is held low after an abort command.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  stream word valid.
- IN_READY  out  1  stream word accepted when IN_VALID & IN_READY.
- IN_DATA  in  32  stream word.
- PROG_CTRL  out  1  instruction-memory write strobe.
- PROG_ADDR  out  ADDR_W  instruction-memory word address.
- PROG_DATA  out  DATA_W  instruction word.
- DATA_CTRL  out  1  data-memory write strobe.
- DATA_ADDR  out  ADDR_W  data-memory word address.
- DATA_DATA  out  DATA_W  data word.
- CORE_RSTn  out  1  core reset, active-low.
- CORE_START  out  1  core start.
- CORE_OK  in  1  core completion flag.
- BUSY  out  1  high in any state except IDLE and DONE.
- DONE  out  1  core finished.
- ERR  out  1  protocol error, sticky until RST or abort.
- RUN_CYCLES  out  32  cycles spent in RUN.

Behaviour:
- Header word fields:
  - [31:30] CMD: 00 load program, 01 load data, 10 start, 11 abort.
  - [20:11] LEN-1, giving 1..1024 payload words.
  - [9:0] base ADDR.
  - [29:21] and [10] reserved, ignored.
- States: IDLE, LOAD, RUN, DONE, ABORT.
- Reset values:
  - State IDLE.
  - All strobes 0; addresses and data 0.
  - CORE_RSTn 0, CORE_START 0.
  - BUSY 0, DONE 0, ERR 0, RUN_CYCLES 0.
  - IN_READY 0 during the RST cycle.
- IDLE:
  - IN_READY=1.
  - CMD 00/01: latch target, ADDR and LEN; go to LOAD.
  - CMD 10: go to RUN. CORE_RSTn rises on the entry edge; CORE_START rises one cycle later. RUN_CYCLES clears on entry.
  - CMD 11 in IDLE: no-op.
- LOAD:
  - IN_READY=1; each accepted word is a payload word.
  - Write latency 1: the cycle after acceptance, the selected CTRL is high for exactly one cycle with the current ADDR and DATA. The other CTRL stays 0.
  - ADDR increments modulo 2^ADDR_W (1023 wraps to 0).
  - After LEN words, return to IDLE. Back-to-back words produce back-to-back strobes.
  - CORE_RSTn remains 0 throughout LOAD.
- RUN:
  - CORE_RSTn=1, CORE_START=1, RUN_CYCLES increments every cycle (saturates at 0xFFFFFFFF).
  - IN_READY=1, but only CMD 11 is acted on. Any other header in RUN sets ERR and is dropped.
  - CORE_OK=1 goes to DONE: DONE=1, RUN_CYCLES frozen, CORE_START stays 1.
  - If CORE_OK and an abort arrive in the same cycle, abort wins.
- DONE:
  - IN_READY=1.
  - CMD 00/01/10: clear DONE, pull CORE_RSTn low, CORE_START low, then proceed as from IDLE.
  - CMD 11: go to ABORT.
- ABORT:
  - CORE_START=0, CORE_RSTn=0 for RST_CYCLES cycles, IN_READY=0.
  - Clears ERR, DONE and RUN_CYCLES, then enters IDLE with CORE_RSTn left at 0.
  - An abort header arriving in LOAD is treated as payload data; there is no in-band abort during LOAD.
- RST during any state forces reset values on the next edge. A partially loaded block is abandoned, with no further strobes.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Each LOAD is followed by one extra checksum word, the XOR of all payload words.
  - IN_READY=1 while it is awaited; the strobe is not issued for it.
  - On mismatch, set ERR. While ERR=1, CMD 10 is refused: no RUN, IDLE is kept.
- When undefined: no checksum word; LOAD ends after LEN words.

Decomposition:
- Shared package holds:
  - loader_cmd_e (CMD_PROG, CMD_DATA, CMD_START, CMD_ABORT).
  - loader_state_e.
  - loader_hdr_t packed struct (cmd, rsvd, len_m1, rsvd, addr).
  - LOADER_LEN_W=10.
- Sub-module loader_mem_writer: the registered strobe/address/data generator with the wrapping address counter, instantiated once and steered by the target select.

Test Plan:
- Header 0x00001000 (prog, LEN=3, ADDR=0) + words 0x00500093, 0x00A00113, 0x002081B3 -> PROG_CTRL pulses at ADDR 0,1,2 one cycle after each accept; DATA_CTRL stays 0; CORE_RSTn stays 0.
- Header 0x400013FF (data, LEN=3, ADDR=1023) + words 1, 2, 3 -> DATA_ADDR sequence 1023, 0, 1.
- Header 0x80000000 -> CORE_RSTn 1 next cycle, CORE_START 1 the cycle after; drive CORE_OK high 20 cycles after START -> DONE=1, RUN_CYCLES=20, frozen.
- In RUN, send header 0x00000000 -> ERR=1, no strobe issued; then 0xC0000000 -> CORE_START 0, CORE_RSTn low 4 cycles, ERR cleared, state IDLE.
- IN_VALID toggling 1,0,1,0 during LOAD of 4 words -> exactly 4 strobes with consecutive addresses, no duplicates.
- With LOADER_CHECKSUM_EN, payload 0xF0, 0x0F and checksum 0x00 -> ERR=1; a following 0x80000000 leaves CORE_START 0.
